// File: rtl/conv_nu_acc_if.sv
// Handshake and data bundle for the ternary-weight convolution accumulator.
// master drives jobs and beats; slave is the accumulator.
interface conv_nu_acc_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned QW    = 8,
  parameter int unsigned AW    = 32
);
  logic                    start;
  logic                    clear;
  logic [7:0]              k_size;
  logic                    unit_en;
  logic [LANES*DW-1:0]     din;
  logic                    din_valid;
  logic                    din_ready;
  logic [2*LANES-1:0]      w_code;
  logic signed [QW-1:0]    pos_w;
  logic signed [QW-1:0]    neg_w1;
  logic signed [QW-1:0]    neg_w2;
  logic signed [AW-1:0]    dout;
  logic                    dout_valid;
  logic                    busy;

  modport master (
    output start, clear, k_size, unit_en, din, din_valid, w_code,
           pos_w, neg_w1, neg_w2,
    input  din_ready, dout, dout_valid, busy
  );

  modport slave (
    input  start, clear, k_size, unit_en, din, din_valid, w_code,
           pos_w, neg_w1, neg_w2,
    output din_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/conv_nu_acc.sv
// Ternary-weight LANES-wide convolution accumulator: decode, multiply, sum, accumulate k taps.
// Optional: define CONV_NU_RELU_EN to clamp negative final results to zero.
module conv_nu_acc #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned QW    = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned K_MAX = 25
) (
  input  logic        clk,
  input  logic        rst,
  conv_nu_acc_if.slave bus
);

  localparam int unsigned PW = DW + QW + 1;
  localparam int unsigned KW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [KW-1:0]        k_eff;
  logic [KW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] psum_q;
  logic                 pvalid;

  logic signed [PW-1:0] prods [LANES];
  logic signed [AW-1:0] lane_sum_c;
  logic signed [AW-1:0] final_c;
  logic signed [AW-1:0] result_c;
  logic [KW-1:0]        k_clamp_c;
  logic                 accept_c;
  logic                 last_c;

  // Per-lane weight decode and unsigned-by-signed product
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0]        d;
    logic [1:0]           c;
    logic signed [QW-1:0] w;

    assign d = bus.din[(LANES-i)*DW-1 -: DW];
    assign c = bus.w_code[(LANES-i)*2-1 -: 2];

    always_comb begin
      w = '0;
      case (c)
        2'b11:   w = bus.pos_w;
        2'b01:   w = bus.neg_w1;
        2'b00:   w = bus.neg_w2;
        default: w = '0;
      endcase
    end

    assign prods[i] = $signed(PW'(d)) * PW'(w);
  end

  always_comb begin
    lane_sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum_c = lane_sum_c + AW'(prods[i]);
    end
  end

  // Tap count clamp: zero means one tap, oversize saturates at K_MAX
  always_comb begin
    k_clamp_c = bus.k_size;
    if (bus.k_size == '0) begin
      k_clamp_c = KW'(1);
    end else if (bus.k_size > KW'(K_MAX)) begin
      k_clamp_c = KW'(K_MAX);
    end
  end

  assign bus.din_ready = (state == ACC) && bus.unit_en;
  assign accept_c      = bus.din_ready && bus.din_valid;
  assign last_c        = accept_c && (cnt == (k_eff - KW'(1)));
  assign final_c       = acc + psum_q;

`ifdef CONV_NU_RELU_EN
  assign result_c = final_c[AW-1] ? '0 : final_c;
`else
  assign result_c = final_c;
`endif

  // Control FSM plus the two-stage psum/accumulate pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      k_eff          <= '0;
      cnt            <= '0;
      acc            <= '0;
      psum_q         <= '0;
      pvalid         <= 1'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.busy       <= 1'b0;
    end else if (bus.clear) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      pvalid         <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            k_eff    <= k_clamp_c;
            cnt      <= '0;
            state    <= ACC;
            bus.busy <= 1'b1;
          end
        end
        ACC: begin
          if (pvalid) begin
            acc <= acc + psum_q;
          end
          pvalid <= accept_c;
          if (accept_c) begin
            psum_q <= lane_sum_c;
            cnt    <= cnt + KW'(1);
            if (last_c) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // psum_q still holds the final beat; fold it straight into the result
          bus.dout       <= result_c;
          bus.dout_valid <= 1'b1;
          acc            <= '0;
          pvalid         <= 1'b0;
          cnt            <= '0;
          state          <= IDLE;
          bus.busy       <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_nu_acc.sv
// Scoreboard bench for conv_nu_acc: directed jobs push expected results, a monitor checks each dout_valid.
module tb_conv_nu_acc;
  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned QW    = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned K_MAX = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_nu_acc_if #(.LANES(LANES), .DW(DW), .QW(QW), .AW(AW)) bus ();

  conv_nu_acc #(.LANES(LANES), .DW(DW), .QW(QW), .AW(AW), .K_MAX(K_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int busy_cycles = 0;
  logic [AW-1:0] exp_q [$];

  function automatic logic [AW-1:0] relu(input logic signed [AW-1:0] v);
`ifdef CONV_NU_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout_valid: got dout=%0d with no result pending, required no pulse",
                 $signed(bus.dout));
      end else begin
        chk("dout", bus.dout, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) if (!rst && bus.din_valid && bus.din_ready) beats++;
  always @(negedge clk) if (bus.busy) busy_cycles++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] k);
    bus.k_size = k;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [7:0] wc);
    bit done;
    done = 1'b0;
    bus.din       = d;
    bus.w_code    = wc;
    bus.din_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (bus.din_ready) begin
        tick();
        done = 1'b1;
      end
    end
    if (!done) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_results();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("results_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.clear = 1'b0; bus.k_size = '0; bus.unit_en = 1'b1;
    bus.din = '0; bus.din_valid = 1'b0; bus.w_code = '0;
    bus.pos_w = 8'sd3; bus.neg_w1 = -8'sd2; bus.neg_w2 = -8'sd5;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_din_ready", 32'(bus.din_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Basic decode: 10*3 + 20*-2 + 30*-5 + 40*0 = -160
    exp_q.push_back(relu(-160));
    start_job(8'd1);
    send_beat({8'd10, 8'd20, 8'd30, 8'd40}, 8'b11_01_00_10);
    bus.din_valid = 1'b0;
    wait_results();
    chk("basic_busy_after", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("basic_dout_hold", bus.dout, relu(-160));

    // Full window: 25 * 4 * 255 * 127 = 3238500
    bus.pos_w = 8'sd127;
    beats = 0;
    busy_cycles = 0;
    exp_q.push_back(32'd3238500);
    start_job(8'd25);
    repeat (25) send_beat(32'hFFFF_FFFF, 8'hFF);
    bus.din_valid = 1'b0;
    wait_results();
    chk("full_beats", 32'(beats), 32'd25);
    chk("full_busy_cycles", 32'(busy_cycles), 32'd26);

    // Stall: 30 - 40 + 300 = 290
    bus.pos_w = 8'sd3;
    beats = 0;
    exp_q.push_back(32'd290);
    start_job(8'd3);
    send_beat({8'd1, 8'd2, 8'd3, 8'd4}, 8'hFF);
    bus.unit_en = 1'b0;
    bus.din     = {8'd5, 8'd5, 8'd5, 8'd5};
    bus.w_code  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_din_ready", 32'(bus.din_ready), 32'd0);
    end
    tick();
    bus.unit_en = 1'b1;
    send_beat({8'd5, 8'd5, 8'd5, 8'd5}, 8'h55);
    send_beat({8'd100, 8'd0, 8'd0, 8'd0}, 8'hFF);
    bus.din_valid = 1'b0;
    wait_results();
    chk("stall_beats", 32'(beats), 32'd3);

    // Clamp low: k_size=0 runs one beat, 4*1*3 = 12
    beats = 0;
    exp_q.push_back(32'd12);
    start_job(8'd0);
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, 8'hFF);
    bus.din_valid = 1'b0;
    wait_results();
    chk("clamp0_beats", 32'(beats), 32'd1);

    // Clamp high: k_size=40 runs 25 beats, 25*4*2*3 = 600
    beats = 0;
    exp_q.push_back(32'd600);
    start_job(8'd40);
    repeat (25) send_beat({8'd2, 8'd2, 8'd2, 8'd2}, 8'hFF);
    wait_results();
    repeat (3) tick();
    bus.din_valid = 1'b0;
    chk("clamp40_beats", 32'(beats), 32'd25);

    // Abort after 10 of 25 beats; no result may appear
    start_job(8'd25);
    repeat (10) send_beat({8'd1, 8'd1, 8'd1, 8'd1}, 8'hFF);
    bus.din_valid = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_din_ready", 32'(bus.din_ready), 32'd0);
    repeat (3) tick();
    bus.k_size = 8'd1;
    bus.start  = 1'b1;
    bus.clear  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.clear  = 1'b0;
    chk("clear_beats_start", 32'(bus.busy), 32'd0);
    // Follow-up job: 10*3 + 7*3 = 51, no residue
    exp_q.push_back(32'd51);
    start_job(8'd2);
    send_beat({8'd10, 8'd0, 8'd0, 8'd0}, 8'hFF);
    send_beat({8'd0, 8'd0, 8'd0, 8'd7}, 8'hFF);
    bus.din_valid = 1'b0;
    wait_results();

    // Async reset mid-ACC, between edges
    start_job(8'd5);
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, 8'hFF);
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, 8'hFF);
    bus.din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout", bus.dout, 32'd0);
    chk("arst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_din_ready", 32'(bus.din_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(relu(-160));
    start_job(8'd1);
    send_beat({8'd10, 8'd20, 8'd30, 8'd40}, 8'b11_01_00_10);
    bus.din_valid = 1'b0;
    wait_results();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/conv_nu_acc.md
Name: conv_nu_acc

Overview:
Parametrised ternary-weight convolution unit with LANES parallel lanes. Each lane decodes a 2-bit weight code into one of three shared 8-bit weights, multiplies by its activation byte, and the lane products are summed. Lane sums are accumulated over k_size accepted beats under a start/valid/ready handshake, then one result word is emitted. It is the next-generation replacement for the fixed 4-lane unit in the CNN accelerator datapath and sits between the activation buffer and the output/partial-sum buffer.

Parameters:
LANES, 4, number of parallel lanes (1..16)
DW, 8, activation width per lane (unsigned)
QW, 8, quantised weight width (signed two's complement)
AW, 32, accumulator and output width (signed)
K_MAX, 25, maximum taps per job; also the k_size clamp value

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin job; sampled only in IDLE
clear  in  1  synchronous abort; returns to IDLE
k_size  in  8  taps per job, latched at start
unit_en  in  1  lane enable; gates acceptance
din  in  LANES*DW  activations; lane i = din[(LANES-i)*DW-1 -: DW]
din_valid  in  1  din and w_code are valid this cycle
din_ready  out  1  beat is accepted when din_valid && din_ready
w_code  in  2*LANES  per-lane code; lane i = w_code[(LANES-i)*2-1 -: 2]
pos_w  in  QW  weight for code 2'b11
neg_w1  in  QW  weight for code 2'b01
neg_w2  in  QW  weight for code 2'b00
dout  out  AW  job result, held until the next result
dout_valid  out  1  one-cycle pulse when dout updates
busy  out  1  high in ACC and DRAIN

Behaviour:
- Reset (rst high, asynchronous): state=IDLE; dout=0; dout_valid=0; busy=0; din_ready=0; accumulator, beat counter, pipeline valid and psum register all cleared.
- Code decode: 11 selects pos_w, 01 selects neg_w1, 00 selects neg_w2, 10 is reserved and gives weight 0.
- Per-lane product: zero-extended din lane times sign-extended weight, width DW+QW+1 signed.
- Lane sum: sign-extended to AW before adding. Accumulation wraps modulo 2^AW with no saturation.
- State IDLE: if start, latch k_eff and go to ACC. If k_size=0, k_eff=1. If k_size>K_MAX, k_eff=K_MAX. Otherwise k_eff=k_size.
- din_ready = (state==ACC) && unit_en. It is combinational from state and unit_en only.
- Stage 1: an accepted beat registers the lane sum into psum_q with pvalid=1 at edge E.
- Stage 2: when pvalid, acc <= acc + psum_q.
- State ACC: count accepted beats. The beat that reaches k_eff moves the FSM to DRAIN at edge E.
- State DRAIN: lasts one cycle. At edge E+1, dout <= acc + psum_q (final), dout_valid <= 1, acc <= 0, state <= IDLE.
- Result latency: dout_valid is high during the cycle after edge E+1, for exactly one cycle.
- unit_en low in ACC: no beats are accepted and the counter holds; the job resumes when unit_en returns.
- start while busy: ignored.
- clear: has priority over every other input in any state. Next edge: state=IDLE, acc=0, counter=0, pvalid=0, no dout_valid. dout keeps its previous value.
- clear and start in the same IDLE cycle: clear wins and start is dropped.
- busy = (state==ACC || state==DRAIN). The earliest new start is accepted in the cycle dout_valid is high.

Optional Feature:
CONV_NU_RELU_EN: when defined, a negative final result is written to dout as 0, and dout_valid timing is unchanged. When undefined, dout carries the raw signed AW-bit sum. The intermediate accumulator is never clamped in either build.

Test Plan:
- Basic decode (LANES=4): k_size=1, pos_w=3, neg_w1=-2, neg_w2=-5, din lanes 10/20/30/40, w_code 11/01/00/10. Required: dout=-160 (0xFFFFFF60) one cycle after the DRAIN edge, single dout_valid pulse, busy low afterwards. RELU build: dout=0.
- Full window: k_size=25, all lanes 255, all codes 11, pos_w=127, din_valid held high. Required: 25 accepted beats, dout=3,238,500, busy high for exactly 26 cycles.
- Stall: k_size=3, toggle unit_en low for 4 cycles after beat 1 with din_valid held high. Required: din_ready low during the stall, exactly 3 beats counted, dout equals the sum of the 3 accepted beats.
- Clamp: k_size=0 gives a 1-beat job. k_size=40 gives 25 accepted beats before dout_valid.
- Abort: clear asserted after beat 10 of 25. Required: IDLE next edge and no dout_valid. A following k_size=2 job gives its correct sum with no residue from the aborted job.
- Async reset: rst asserted mid-ACC between clock edges. Required: all outputs 0 immediately, before the next edge. After release, start behaves normally.
